// File: rtl/rf_writeback.sv
// Write-side front end of the register file: arbitrates ALU and buffered load results onto the
// single write port and tracks which registers still have a write in flight.
module rf_writeback #(
  parameter int unsigned DATA_W    = 28,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MEM_DEPTH = 4,
  localparam int unsigned NumRegs  = 2 ** ADDR_W,
  localparam int unsigned PtrW     = $clog2(MEM_DEPTH),
  localparam int unsigned LevelW   = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_dest_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [ADDR_W-1:0] mem_dest_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_dest_i,
  output logic [NumRegs-1:0] busy_o,
  output logic [LevelW-1:0] mem_level_o,
  output logic              rf_wen_o,
  output logic [ADDR_W-1:0] rf_dest_sel_o,
  output logic [DATA_W-1:0] rf_data_in_o
);

  logic [ADDR_W-1:0]  fifo_dest_q [MEM_DEPTH];
  logic [DATA_W-1:0]  fifo_data_q [MEM_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]  level_q, level_d;
  logic               prefer_mem_q, prefer_mem_d;
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0]  rf_dest_q, rf_dest_d;
  logic [DATA_W-1:0]  rf_data_q, rf_data_d;

  logic push, grant_alu, grant_mem, mem_cand;
  logic [ADDR_W-1:0] win_dest;
  logic [DATA_W-1:0] win_data;

  assign mem_ready_o = rst_ni & (level_q != LevelW'(MEM_DEPTH));
  assign push        = mem_valid_i & mem_ready_o;
  assign mem_cand    = (level_q != '0);

  // Round-robin: on contention the source not granted last wins.
  assign grant_alu   = alu_valid_i & (~mem_cand | ~prefer_mem_q);
  assign grant_mem   = mem_cand & (~alu_valid_i | prefer_mem_q);
  assign alu_ready_o = rst_ni & grant_alu;

  assign win_dest = grant_alu ? alu_dest_i : fifo_dest_q[rd_ptr_q];
  assign win_data = grant_alu ? alu_data_i : fifo_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    prefer_mem_d = prefer_mem_q;
    rf_wen_d     = 1'b0;
    rf_dest_d    = rf_dest_q;
    rf_data_d    = rf_data_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (grant_mem) rd_ptr_d = rd_ptr_q + PtrW'(1);
    level_d = level_q + LevelW'(push) - LevelW'(grant_mem);
    if (grant_alu) begin
      prefer_mem_d = 1'b1;
    end else if (grant_mem) begin
      prefer_mem_d = 1'b0;
    end
    if (grant_alu | grant_mem) begin
      rf_wen_d  = (win_dest != '0);
      rf_dest_d = win_dest;
      rf_data_d = win_data;
    end
  end

  // Clear on the edge after the write lands; a new reservation of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_dest_q] = 1'b0;
    if (iss_valid_i && (iss_dest_i != '0)) busy_d[iss_dest_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      prefer_mem_q <= 1'b0;
      busy_q       <= '0;
      rf_wen_q     <= 1'b0;
      rf_dest_q    <= '0;
      rf_data_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      prefer_mem_q <= prefer_mem_d;
      busy_q       <= busy_d;
      rf_wen_q     <= rf_wen_d;
      rf_dest_q    <= rf_dest_d;
      rf_data_q    <= rf_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_dest_q[wr_ptr_q] <= mem_dest_i;
      fifo_data_q[wr_ptr_q] <= mem_data_i;
    end
  end

  assign busy_o        = busy_q;
  assign mem_level_o   = level_q;
  assign rf_wen_o      = rf_wen_q;
  assign rf_dest_sel_o = rf_dest_q;
  assign rf_data_in_o  = rf_data_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Randomised and directed bench for rf_writeback, checked against a queue-based model of the
// arbitration, load FIFO, scoreboard and register file.
module tb_rf_writeback;

  localparam int Depth = 4;

  logic        clk, rst_ni;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, iss_valid, rf_wen;
  logic [3:0]  alu_dest, mem_dest, iss_dest, rf_dest_sel;
  logic [27:0] alu_data, mem_data, rf_data_in;
  logic [15:0] busy;
  logic [2:0]  mem_level;

  rf_writeback dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_dest_i(alu_dest),
    .alu_data_i(alu_data),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_dest_i(mem_dest),
    .mem_data_i(mem_data),
    .iss_valid_i(iss_valid), .iss_dest_i(iss_dest),
    .busy_o(busy), .mem_level_o(mem_level),
    .rf_wen_o(rf_wen), .rf_dest_sel_o(rf_dest_sel), .rf_data_in_o(rf_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file written at the negedge inside the write cycle.
  logic [27:0] tb_rf [16];
  always @(negedge clk) if (rf_wen) tb_rf[rf_dest_sel] <= rf_data_in;

  typedef struct packed {logic [3:0] dest; logic [27:0] data;} ent_t;
  ent_t        mq[$];
  bit          alu_turn, exp_wen, m_ga, m_push, s_alu_ready;
  logic [3:0]  exp_dest;
  logic [27:0] exp_data;
  logic [15:0] exp_busy;
  logic [27:0] exp_rf [16];
  bit          exp_rf_vld [16];
  int          n_checks = 0, n_pass = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    alu_turn = 1'b1;
    exp_wen  = 1'b0;
    exp_dest = '0;
    exp_data = '0;
    exp_busy = '0;
    m_ga     = 1'b0;
    m_push   = 1'b0;
  endtask

  // Compare every observable output against the model before the coming edge.
  task automatic drive_check();
    int sz;
    bit ga;
    int k;
    #1;
    sz = mq.size();
    ga = alu_valid && (sz == 0 || alu_turn);
    s_alu_ready = alu_ready;
    check_eq("alu_ready", 64'(alu_ready), 64'(ga));
    check_eq("mem_ready", 64'(mem_ready), 64'(sz < Depth));
    check_eq("mem_level", 64'(mem_level), 64'(sz));
    check_eq("busy", 64'(busy), 64'(exp_busy));
    check_eq("rf_wen", 64'(rf_wen), 64'(exp_wen));
    check_eq("rf_dest_sel", 64'(rf_dest_sel), 64'(exp_dest));
    check_eq("rf_data_in", 64'(rf_data_in), 64'(exp_data));
    k = cyc % 16;
    if (exp_wen && exp_dest == 4'(k)) check_eq("regfile", 64'(tb_rf[k]), 64'(exp_data));
    else if (exp_rf_vld[k]) check_eq("regfile", 64'(tb_rf[k]), 64'(exp_rf[k]));
  endtask

  task automatic edge_update();
    int sz;
    bit ga, gm, push;
    ent_t w;
    @(posedge clk);
    sz   = mq.size();
    ga   = alu_valid && (sz == 0 || alu_turn);
    gm   = (sz > 0) && !ga;
    push = mem_valid && (sz < Depth);
    if (exp_wen) begin
      exp_rf[exp_dest]     = exp_data;
      exp_rf_vld[exp_dest] = 1'b1;
      exp_busy[exp_dest]   = 1'b0;
    end
    if (iss_valid && iss_dest != 0) exp_busy[iss_dest] = 1'b1;
    if (ga) w = '{dest: alu_dest, data: alu_data};
    else if (gm) w = mq.pop_front();
    if (push) mq.push_back('{dest: mem_dest, data: mem_data});
    if (ga || gm) begin
      alu_turn = gm;
      exp_wen  = (w.dest != 0);
      exp_dest = w.dest;
      exp_data = w.data;
    end else begin
      exp_wen = 1'b0;
    end
    m_ga   = ga;
    m_push = push;
    cyc++;
  endtask

  task automatic step();
    drive_check();
    edge_update();
    @(negedge clk);
  endtask

  // Replace consumed transfers with fresh ones; unaccepted ones are held stable.
  task automatic next_inputs(input int pa, input int pm, input int pi, input bit zero_ok);
    int lo;
    lo = zero_ok ? 0 : 1;
    if (!alu_valid || m_ga) begin
      alu_valid = ($urandom_range(0, 99) < pa);
      alu_dest  = 4'($urandom_range(lo, 15));
      alu_data  = 28'($urandom);
    end
    if (!mem_valid || m_push) begin
      mem_valid = ($urandom_range(0, 99) < pm);
      mem_dest  = 4'($urandom_range(lo, 15));
      mem_data  = 28'($urandom);
    end
    iss_valid = ($urandom_range(0, 99) < pi);
    iss_dest  = 4'($urandom_range(lo, 15));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wen"}, 64'(rf_wen), 64'(0));
    check_eq({tag, "_dest"}, 64'(rf_dest_sel), 64'(0));
    check_eq({tag, "_data"}, 64'(rf_data_in), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_lvl"}, 64'(mem_level), 64'(0));
    check_eq({tag, "_alu_rdy"}, 64'(alu_ready), 64'(0));
    check_eq({tag, "_mem_rdy"}, 64'(mem_ready), 64'(0));
  endtask

  initial begin
    logic [3:0] pattern;
    bit reached;
    rst_ni = 1'b0;
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = '0;
    mem_valid = 1'b1; mem_dest = 4'd2; mem_data = '0;
    iss_valid = 1'b1; iss_dest = 4'd3;
    for (int i = 0; i < 16; i++) exp_rf_vld[i] = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("init");
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // ALU only
    alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 28'h0ABCDEF;
    step();
    alu_valid = 1'b0;
    step();
    check_eq("r5", 64'(tb_rf[5]), 64'(28'h0ABCDEF));

    // Two loads alone, then contention for four cycles
    for (int i = 0; i < 2; i++) begin
      next_inputs(0, 100, 0, 1'b0);
      step();
    end
    pattern = '0;
    for (int i = 0; i < 4; i++) begin
      next_inputs(100, 100, 0, 1'b0);
      step();
      pattern = {pattern[2:0], s_alu_ready};
    end
    check_eq("contention", 64'(pattern), 64'(4'b1010));

    // Fill the FIFO while the ALU streams, then keep pushing against a full FIFO
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      next_inputs(100, 100, 0, 1'b0);
      step();
      reached = (mq.size() == Depth);
    end
    check_eq("full_lvl", 64'(mem_level), 64'(Depth));
    check_eq("full_rdy", 64'(mem_ready), 64'(0));
    for (int i = 0; i < 6; i++) begin
      next_inputs(100, 100, 100, 1'b0);
      step();
    end

    // Reset in the middle of a write cycle
    next_inputs(100, 100, 100, 1'b0);
    drive_check();
    edge_update();
    #1;
    check_eq("pre_rst_wen", 64'(rf_wen), 64'(exp_wen));
    check_eq("pre_rst_lvl", 64'(mem_level), 64'(mq.size()));
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    check_eq("post_rst_lvl", 64'(mem_level), 64'(0));
    check_eq("post_rst_busy", 64'(busy), 64'(0));

    // Scoreboard set, commit, reissue on the clear edge, final clear
    iss_valid = 1'b1; iss_dest = 4'd3;
    step();
    check_eq("busy3_set", 64'(busy[3]), 64'(1));
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 28'h1234567;
    step();
    check_eq("busy3_wen", 64'(busy[3]), 64'(1));
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_dest = 4'd3;
    step();
    check_eq("busy3_reissue", 64'(busy[3]), 64'(1));
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_data = 28'h7654321;
    step();
    check_eq("busy3_hold", 64'(busy[3]), 64'(1));
    alu_valid = 1'b0;
    step();
    check_eq("busy3_clear", 64'(busy[3]), 64'(0));
    check_eq("r3", 64'(tb_rf[3]), 64'(28'h7654321));

    // Destination zero is consumed but never written or reserved
    alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 28'hFFFFFFF;
    iss_valid = 1'b1; iss_dest = 4'd0;
    step();
    check_eq("d0_wen", 64'(rf_wen), 64'(0));
    check_eq("d0_busy", 64'(busy), 64'(0));
    alu_valid = 1'b0; iss_valid = 1'b0;
    m_ga = 1'b0; m_push = 1'b0;

    for (int i = 0; i < 400; i++) begin
      next_inputs(60, 50, 40, 1'b1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
